// File: rtl/conv4_accum.sv
// conv4_accum: accumulates CH_NUM pairs of conv-core partial sums on top of a bias, then requantizes to OUT_W.
// Ports:
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   en                 level enable: run groups (1) or abort/idle (0)
//   end_conv4          strobe qualifying i_sum1/i_sum2
//   i_sum1, i_sum2     signed IN_W partial sums
//   i_bias             signed ACC_W bias loaded at each group start
//   i_ready            downstream accepts o_act1/o_act2
//   o_acc_rdy          block accepts end_conv4 (ACC state)
//   o_valid            o_act1/o_act2 valid (OUT state)
//   o_act1, o_act2     signed OUT_W requantized activations
//   o_drop             sticky: a strobe arrived while o_acc_rdy was low
module conv4_accum #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int CH_NUM = 16,
  parameter int SHIFT  = 8,
  parameter int RELU   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    end_conv4,
  input  logic signed [IN_W-1:0]  i_sum1,
  input  logic signed [IN_W-1:0]  i_sum2,
  input  logic signed [ACC_W-1:0] i_bias,
  input  logic                    i_ready,
  output logic                    o_acc_rdy,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_act1,
  output logic signed [OUT_W-1:0] o_act2,
  output logic                    o_drop
);
  localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d, sum1, sum2;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [OUT_W-1:0] act1_q, act1_d, act2_q, act2_d;
  logic                    drop_q, drop_d;
  logic                    acpt, last, load;

  // One extra bit keeps the rounding add from overflowing before the shift.
  function automatic logic signed [OUT_W-1:0] rq(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = ($signed({a[ACC_W-1], a}) + RND) >>> SHIFT;
    if (RELU != 0 && r[ACC_W]) r = '0;
    return r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
  endfunction

  assign sum1 = acc1_q + ACC_W'(i_sum1);
  assign sum2 = acc2_q + ACC_W'(i_sum2);
  assign acpt = state_q == ACC && en && end_conv4;
  assign last = acpt && cnt_q == CW'(CH_NUM-1);
  // Any entry into ACC (from IDLE or from a completed handshake) starts a fresh group.
  assign load = state_d == ACC && state_q != ACC;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      act1_q  <= '0;
      act2_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      drop_q  <= drop_d;
    end
  end

  // OUT ignores en until the pending result has been accepted.
  always_comb begin
    state_d = state_q == IDLE ? (en ? ACC : IDLE)
            : state_q == ACC  ? (!en ? IDLE : last ? OUT : ACC)
            : i_ready ? (en ? ACC : IDLE) : OUT;
  end

  always_comb begin
    acc1_d = load ? i_bias : acpt ? sum1 : state_d == IDLE ? '0 : acc1_q;
    acc2_d = load ? i_bias : acpt ? sum2 : state_d == IDLE ? '0 : acc2_q;
    cnt_d  = load ? '0 : acpt ? cnt_q + CW'(1) : state_d == IDLE ? '0 : cnt_q;
    act1_d = last ? rq(sum1) : act1_q;
    act2_d = last ? rq(sum2) : act2_q;
    drop_d = drop_q | (end_conv4 && state_q != ACC);
  end

  assign o_acc_rdy = state_q == ACC;
  assign o_valid   = state_q == OUT;
  assign o_act1    = act1_q;
  assign o_act2    = act2_q;
  assign o_drop    = drop_q;
endmodule

// File: tb/tb_conv4_accum.sv
// tb_conv4_accum: randomized + directed bench for conv4_accum against a transaction-level model.
module tb_conv4_accum;
  localparam int IN_W = 16, ACC_W = 24, OUT_W = 8, CH = 4, SH = 4;

  logic clk = 0, rstn = 0, en = 0, end_conv4 = 0, i_ready = 1;
  logic signed [IN_W-1:0] i_sum1 = '0, i_sum2 = '0;
  logic signed [ACC_W-1:0] i_bias = '0;
  logic rdy, vld, drp, rdy0, vld0, drp0;
  logic signed [OUT_W-1:0] a1, a2, b1, b2;
  int checks = 0, errors = 0;

  bit m_col, m_pend, m_drop;
  int m_beats;
  longint m_s1, m_s2;

  always #5 clk = ~clk;

  conv4_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CH_NUM(CH), .SHIFT(SH), .RELU(1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .end_conv4(end_conv4), .i_sum1(i_sum1), .i_sum2(i_sum2),
    .i_bias(i_bias), .i_ready(i_ready), .o_acc_rdy(rdy), .o_valid(vld), .o_act1(a1), .o_act2(a2),
    .o_drop(drp));

  conv4_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CH_NUM(CH), .SHIFT(SH), .RELU(0)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .end_conv4(end_conv4), .i_sum1(i_sum1), .i_sum2(i_sum2),
    .i_bias(i_bias), .i_ready(i_ready), .o_acc_rdy(rdy0), .o_valid(vld0), .o_act1(b1), .o_act2(b2),
    .o_drop(drp0));

  function automatic longint rq(longint a, bit relu);
    longint hi = (longint'(1) << (OUT_W-1)) - 1;
    longint r = (a + (longint'(1) << (SH-1))) >>> SH;
    if (relu && r < 0) r = 0;
    return r > hi ? hi : r < -hi-1 ? -hi-1 : r;
  endfunction

  function automatic int rnd(int m);
    return int'($urandom_range(2*m)) - m;
  endfunction

  task automatic chk(string n, longint g, longint e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, g, e, $time);
    end
  endtask

  task automatic drive(bit e, bit s, int x1, int x2, int b, bit r);
    @(negedge clk);
    en = e; end_conv4 = s; i_sum1 = IN_W'(x1); i_sum2 = IN_W'(x2); i_bias = ACC_W'(b); i_ready = r;
  endtask

  task automatic start_group();
    m_col = 1; m_beats = 0; m_s1 = i_bias; m_s2 = i_bias;
  endtask

  // Transaction model: a group collects CH accepted beats on top of the bias,
  // then its result is pending until accepted; strobes outside collection are drops.
  always @(posedge clk) begin
    if (!rstn) begin
      m_col = 0; m_pend = 0; m_drop = 0; m_beats = 0; m_s1 = 0; m_s2 = 0;
    end else if (m_pend) begin
      if (end_conv4) m_drop = 1;
      if (i_ready) begin
        m_pend = 0;
        if (en) start_group();
      end
    end else if (m_col) begin
      if (!en) m_col = 0;
      else if (end_conv4) begin
        m_s1 += i_sum1; m_s2 += i_sum2; m_beats++;
        if (m_beats == CH) begin m_col = 0; m_pend = 1; end
      end
    end else begin
      if (end_conv4) m_drop = 1;
      if (en) start_group();
    end
    #1;
    chk("acc_rdy", rdy, m_col);
    chk("valid", vld, m_pend);
    chk("drop", drp, m_drop);
    chk("valid_r0", vld0, m_pend);
    chk("drop_r0", drp0, m_drop);
    if (m_pend) begin
      chk("act1", a1, rq(m_s1, 1));
      chk("act2", a2, rq(m_s2, 1));
      chk("act1_r0", b1, rq(m_s1, 0));
      chk("act2_r0", b2, rq(m_s2, 0));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", vld, 0); chk("rst_rdy", rdy, 0); chk("rst_act1", a1, 0);
    chk("rst_act2", a2, 0); chk("rst_drop", drp, 0);
    rstn = 1;
    // bias 8, 4x(16,-100): 72 -> 5, -392 -> ReLU 0 / -24
    drive(1, 0, 0, 0, 8, 1);
    repeat (4) drive(1, 1, 16, -100, 8, 1);
    @(posedge clk); #2;
    chk("l037_valid", vld, 1); chk("l037_act1", a1, 5); chk("l037_act2", a2, 0); chk("l037_r0_act2", b2, -24);
    drive(0, 0, 0, 0, 0, 1);
    // bias 8, 4x(1000,-3): saturate 127; -4 rounds to 0
    drive(1, 0, 0, 0, 8, 1);
    repeat (4) drive(1, 1, 1000, -3, 8, 1);
    @(posedge clk); #2;
    chk("l038_act1", a1, 127); chk("l038_act2", a2, 0); chk("l038_r0_act1", b1, 127); chk("l038_r0_act2", b2, 0);
    drive(0, 0, 0, 0, 0, 1);
    // three back-to-back random groups
    drive(1, 0, 0, 0, rnd(2000), 1);
    for (int g = 0; g < 3; g++) begin
      repeat (4) drive(1, 1, rnd(300), rnd(300), 0, 1);
      drive(g < 2, 0, 0, 0, rnd(2000), 1);
    end
    @(posedge clk); #2;
    chk("l042_nodrop", drp, 0);
    // stall in OUT with a strobe in the stall window
    drive(1, 0, 0, 0, 8, 0);
    repeat (4) drive(1, 1, 16, -100, 8, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 99, 99, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("l039_valid", vld, 1); chk("l039_act1", a1, 5); chk("l039_drop", drp, 1);
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk); #2;
    chk("l039_done", vld, 0);
    // abort after 2 strobes, then a fresh group with bias 0
    drive(1, 0, 0, 0, 100, 1);
    repeat (2) drive(1, 1, 50, 50, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk); #2;
    chk("l040_rdy", rdy, 0); chk("l040_valid", vld, 0);
    drive(1, 0, 0, 0, 0, 1);
    repeat (4) drive(1, 1, 32, 0, 0, 1);
    @(posedge clk); #2;
    chk("l040_act1", a1, 8); chk("l040_act2", a2, 0);
    drive(0, 0, 0, 0, 0, 1);
    // reset mid-group
    drive(1, 0, 0, 0, 8, 1);
    repeat (3) drive(1, 1, 16, 16, 0, 1);
    @(negedge clk);
    rstn = 0; en = 0; end_conv4 = 0; i_sum1 = '0; i_sum2 = '0; i_bias = '0;
    #1;
    chk("l041_rdy", rdy, 0); chk("l041_valid", vld, 0); chk("l041_act1", a1, 0); chk("l041_drop", drp, 0);
    @(negedge clk); rstn = 1;
    drive(1, 0, 0, 0, 8, 1);
    repeat (4) drive(1, 1, 16, 16, 0, 1);
    @(posedge clk); #2;
    chk("l041_act1", a1, 5); chk("l041_act2", a2, 5);
    drive(0, 0, 0, 0, 0, 1);
    // random stress
    for (int i = 0; i < 800; i++) begin
      bit big;
      big = $urandom_range(9) == 0;
      drive($urandom_range(9) != 0, $urandom_range(1) == 1,
            big ? rnd(32767) : rnd(300), big ? rnd(32767) : rnd(300),
            big ? rnd(1 << 20) : rnd(3000), $urandom_range(2) != 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv4_accum.md
CONV4_ACCUM -- requirements
Module: conv4_accum

Interface
REQ-001 SHALL have parameter IN_W, default 16, partial-sum width (2*conv4_width) of o_sum1/o_sum2.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; legal only if ACC_W >= IN_W+clog2(CH_NUM)+2.
REQ-003 SHALL have parameter OUT_W, default 8, signed output activation width.
REQ-004 SHALL have parameter CH_NUM, default 16, input channels accumulated per output; legal range 1..256.
REQ-005 SHALL have parameter SHIFT, default 8, requant right-shift amount; legal range 1..ACC_W-2.
REQ-006 SHALL have parameter RELU, default 1; 1 means negative results clamp to 0.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, named as in the codebase: clk  input  1  rising-edge clock.
REQ-008 rstn  input  1  asynchronous active-low reset.
REQ-009 en  input  1  level enable; 1 means run accumulation groups, 0 means abort or idle.
REQ-010 end_conv4  input  1  single-cycle strobe marking i_sum1/i_sum2 valid (end_conv4 of the conv core).
REQ-011 i_sum1, i_sum2  input  IN_W  signed partial sums from the conv core.
REQ-012 i_bias  input  ACC_W  signed bias shared by both outputs.
REQ-013 i_ready  input  1  downstream accepts the output.
REQ-014 o_acc_rdy  output  1  block accepts end_conv4 this cycle.
REQ-015 o_valid  output  1  o_act1/o_act2 valid.
REQ-016 o_act1, o_act2  output  OUT_W  signed requantized activations.
REQ-017 o_drop  output  1  sticky error: end_conv4 arrived while o_acc_rdy=0.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACC and OUT.
REQ-019 IDLE: when en=1, SHALL load acc1=acc2=i_bias, set ch_cnt=0, and go to ACC next cycle.
REQ-020 ACC: SHALL hold o_acc_rdy=1; on end_conv4, acc1+=sext(i_sum1), acc2+=sext(i_sum2) and ch_cnt++.
REQ-021 ACC: on end_conv4 with ch_cnt==CH_NUM-1, SHALL write the requantized final sums (including this beat) into o_act1/o_act2 and go to OUT; o_valid=1 the next cycle (1-cycle latency from the last strobe).
REQ-022 ACC with en=0: SHALL abort to IDLE, clear acc and ch_cnt, produce no output, and ignore end_conv4 in that cycle.
REQ-023 OUT: SHALL hold o_valid=1, o_acc_rdy=0, and o_act1/o_act2 stable until i_ready=1.
REQ-024 OUT with i_ready=1 and en=1: SHALL complete the handshake, reload acc from i_bias, set ch_cnt=0, and go to ACC.
REQ-025 OUT with i_ready=1 and en=0: SHALL go to IDLE.
REQ-026 OUT: en=0 SHALL NOT drop a pending output; the handshake completes first.
REQ-027 end_conv4 while o_acc_rdy=0 (IDLE or OUT): SHALL discard the data and set o_drop=1 until reset.
REQ-028 Requant per output: r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift with round half up, computed at ACC_W+1 bits with no internal overflow.
REQ-029 If RELU=1, negative r SHALL become 0.
REQ-030 r SHALL then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-031 Accumulation SHALL be two's-complement at ACC_W; the legal-width rule in REQ-002 guarantees no wrap.
REQ-032 CH_NUM=1: the first end_conv4 in ACC SHALL go directly to OUT.
REQ-033 o_valid SHALL never be asserted except in OUT; o_acc_rdy=1 exactly in ACC.

Reset
REQ-034 On rstn=0, asynchronously: state=IDLE, acc1=acc2=0, ch_cnt=0, o_valid=0, o_acc_rdy=0, o_act1=o_act2=0, o_drop=0.
REQ-035 Reset mid-operation SHALL discard all partial accumulation.
REQ-036 After rstn rises, the first group SHALL start only per REQ-019.

Verification (CH_NUM=4, SHIFT=4, OUT_W=8, RELU=1)
REQ-037 bias=8, 4 strobes i_sum1=16, i_sum2=-100 -> o_act1=5 (72+8>>4), o_act2=0 (-384 clamped by ReLU); o_valid rises 1 cycle after the 4th strobe.
REQ-038 bias=8, 4 strobes i_sum1=1000, i_sum2=-3 -> o_act1=127 (saturated), o_act2=0; with RELU=0, o_act2=0 ((-4+8)>>4).
REQ-039 i_ready=0 for 3 cycles in OUT, plus one end_conv4 in that window -> o_act stable, o_valid held, o_drop=1; handshake completes when i_ready=1.
REQ-040 en drops after 2 strobes -> IDLE, o_valid stays 0; en re-raised with bias=0 and 4 strobes i_sum1=32 -> o_act1=8 (earlier beats not included).
REQ-041 rstn pulsed low after 3 strobes -> all outputs 0 immediately; restarted group of 4 strobes i_sum1=16, bias=8 -> o_act1=5.
REQ-042 en held 1 with i_ready=1 over 3 back-to-back groups -> 3 correct outputs, no o_drop.
